sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 121 ++++++++++++
 tb/tb_sync_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, optional registered output stage, level flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int NDATABITS = 32,
  parameter int NADDRBITS = 3,
  parameter int OUTREG    = 0,
  parameter int AFULL     = (1 << NADDRBITS) - 1,
  parameter int AEMPTY    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NDATABITS-1:0] dataW_i,
  input  logic                 validW_i,
  output logic                 readyW_o,
  output logic [NDATABITS-1:0] dataR_o,
  output logic                 validR_o,
  input  logic                 readyR_i,
  output logic [NADDRBITS:0]   level_o,
  output logic                 almostFull_o,
  output logic                 almostEmpty_o
);

  localparam int DEPTH = 1 << NADDRBITS;
  localparam logic [NADDRBITS:0] PTR_ONE = 1;

  logic [NDATABITS-1:0] mem [DEPTH];
  logic [NADDRBITS:0]   wptr  = '0;
  logic [NADDRBITS:0]   rptr  = '0;
  logic [NADDRBITS:0]   level = '0;

  logic mem_full;
  logic mem_empty;
  logic wr_acc;
  logic rd_acc;
  logic mem_rd;

  assign mem_full  = (wptr[NADDRBITS-1:0] == rptr[NADDRBITS-1:0]) &&
                     (wptr[NADDRBITS] != rptr[NADDRBITS]);
  assign mem_empty = (wptr == rptr);

  // No write-through: a full memory refuses writes even when a read drains it.
  assign readyW_o = !mem_full && !reset_i;
  assign wr_acc   = validW_i && readyW_o;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wptr[NADDRBITS-1:0]] <= dataW_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (mem_rd) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic                 out_valid = 1'b0;
      logic [NDATABITS-1:0] out_data  = '0;

      // Refill when the stage is empty or its word leaves this cycle.
      assign mem_rd = !mem_empty && (!out_valid || readyR_i);
      assign rd_acc = out_valid && readyR_i;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          out_valid <= 1'b0;
        end else if (mem_rd) begin
          out_valid <= 1'b1;
        end else if (rd_acc) begin
          out_valid <= 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        if (mem_rd) begin
          out_data <= mem[rptr[NADDRBITS-1:0]];
        end
      end

      assign validR_o = out_valid;
      assign dataR_o  = out_data;
    end else begin : g_fwft
      assign validR_o = !mem_empty;
      assign dataR_o  = mem[rptr[NADDRBITS-1:0]];
      assign rd_acc   = validR_o && readyR_i;
      assign mem_rd   = rd_acc;
    end
  endgenerate

  assign level_o       = level;
  assign almostFull_o  = int'(level) >= AFULL;
  assign almostEmpty_o = int'(level) <= AEMPTY;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for sync_fifo: one FWFT instance (OUTREG=0) and one registered-output
// instance (OUTREG=1), both 8-bit wide and 4 words deep.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, vw0 = 1'b0, rr0 = 1'b0;
  logic [7:0] dw0 = '0;
  logic       rdyw0, vr0, af0, ae0;
  logic [7:0] dr0;
  logic [2:0] lvl0;

  logic       rst1 = 1'b1, vw1 = 1'b0, rr1 = 1'b0;
  logic [7:0] dw1 = '0;
  logic       rdyw1, vr1, af1, ae1;
  logic [7:0] dr1;
  logic [2:0] lvl1;

  sync_fifo #(.NDATABITS(8), .NADDRBITS(2), .OUTREG(0), .AFULL(3), .AEMPTY(1)) dut0 (
    .clk_i(clk), .reset_i(rst0), .dataW_i(dw0), .validW_i(vw0), .readyW_o(rdyw0),
    .dataR_o(dr0), .validR_o(vr0), .readyR_i(rr0), .level_o(lvl0),
    .almostFull_o(af0), .almostEmpty_o(ae0)
  );

  sync_fifo #(.NDATABITS(8), .NADDRBITS(2), .OUTREG(1), .AFULL(3), .AEMPTY(1)) dut1 (
    .clk_i(clk), .reset_i(rst1), .dataW_i(dw1), .validW_i(vw1), .readyW_o(rdyw1),
    .dataR_o(dr1), .validR_o(vr1), .readyR_i(rr1), .level_o(lvl1),
    .almostFull_o(af1), .almostEmpty_o(ae1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       vw;
    logic [7:0] dw;
    logic       rr;
    logic       ew;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] el;
    logic       eaf;
    logic       eae;
    logic       cd;
  } vec_t;

  initial begin
    vec_t       tbl [18];
    logic [7:0] q[$];
    int         sent, got;
    logic       hold;
    logic [7:0] hdata;

    //            rst  vw   dw     rr   ew   ev   ed     el    af   ae   cd
    tbl[0]  = '{1'b1,1'b1,8'h99,1'b0,1'b0,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b1,8'h11,1'b0,1'b1,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
    tbl[2]  = '{1'b0,1'b1,8'h22,1'b0,1'b1,1'b1,8'h11,3'd1,1'b0,1'b1,1'b1};
    tbl[3]  = '{1'b0,1'b1,8'h33,1'b0,1'b1,1'b1,8'h11,3'd2,1'b0,1'b0,1'b1};
    tbl[4]  = '{1'b0,1'b1,8'h44,1'b0,1'b1,1'b1,8'h11,3'd3,1'b1,1'b0,1'b1};
    tbl[5]  = '{1'b0,1'b1,8'h55,1'b0,1'b0,1'b1,8'h11,3'd4,1'b1,1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b1,8'h55,1'b1,1'b0,1'b1,8'h11,3'd4,1'b1,1'b0,1'b1};
    tbl[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h22,3'd3,1'b1,1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h33,3'd2,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h44,3'd1,1'b0,1'b1,1'b1};
    tbl[10] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,8'hA1,1'b0,1'b1,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b1,8'hA2,1'b0,1'b1,1'b1,8'hA1,3'd1,1'b0,1'b1,1'b1};
    tbl[13] = '{1'b0,1'b1,8'hA3,1'b0,1'b1,1'b1,8'hA1,3'd2,1'b0,1'b0,1'b1};
    tbl[14] = '{1'b1,1'b1,8'hB0,1'b1,1'b0,1'b1,8'hA1,3'd3,1'b1,1'b0,1'b1};
    tbl[15] = '{1'b0,1'b1,8'h77,1'b0,1'b1,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h77,3'd1,1'b0,1'b1,1'b1};
    tbl[17] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};

    @(posedge clk); #1;

    // FWFT instance: fill, refuse, drain, mid-operation reset
    for (int i = 0; i < 18; i++) begin
      rst0 = tbl[i].rst; vw0 = tbl[i].vw; dw0 = tbl[i].dw; rr0 = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_readyW", i), 32'(rdyw0), 32'(tbl[i].ew));
      chk($sformatf("vec%0d_validR", i), 32'(vr0),   32'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i),  32'(lvl0),  32'(tbl[i].el));
      chk($sformatf("vec%0d_afull", i),  32'(af0),   32'(tbl[i].eaf));
      chk($sformatf("vec%0d_aempty", i), 32'(ae0),   32'(tbl[i].eae));
      if (tbl[i].cd) chk($sformatf("vec%0d_dataR", i), 32'(dr0), 32'(tbl[i].ed));
      @(posedge clk); #1;
    end

    // FWFT streaming with simultaneous read/write across pointer wrap
    for (int k = 0; k <= 20; k++) begin
      vw0 = (k < 20); dw0 = 8'(k); rr0 = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        chk("stream_first_validR", 32'(vr0), 32'd0);
        chk("stream_first_level", 32'(lvl0), 32'd0);
      end else begin
        chk($sformatf("stream%0d_validR", k), 32'(vr0), 32'd1);
        chk($sformatf("stream%0d_dataR", k), 32'(dr0), 32'(k - 1));
        chk($sformatf("stream%0d_level", k), 32'(lvl0), 32'd1);
      end
      @(posedge clk); #1;
    end
    vw0 = 1'b0; rr0 = 1'b0;
    @(negedge clk);
    chk("stream_end_validR", 32'(vr0), 32'd0);
    chk("stream_end_level", 32'(lvl0), 32'd0);
    @(posedge clk); #1;

    // Registered-output instance: reset behaviour
    rst1 = 1'b1; vw1 = 1'b1; dw1 = 8'hEE;
    @(negedge clk);
    chk("or_reset_readyW", 32'(rdyw1), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0; vw1 = 1'b0;
    @(negedge clk);
    chk("or_post_reset_readyW", 32'(rdyw1), 32'd1);
    chk("or_post_reset_validR", 32'(vr1), 32'd0);
    chk("or_post_reset_level", 32'(lvl1), 32'd0);
    chk("or_post_reset_aempty", 32'(ae1), 32'd1);
    chk("or_post_reset_afull", 32'(af1), 32'd0);
    @(posedge clk); #1;

    // Two-cycle write-to-valid latency
    vw1 = 1'b1; dw1 = 8'hA5; rr1 = 1'b0;
    @(negedge clk);
    chk("lat_c0_validR", 32'(vr1), 32'd0);
    @(posedge clk); #1;
    vw1 = 1'b0;
    @(negedge clk);
    chk("lat_c1_validR", 32'(vr1), 32'd0);
    chk("lat_c1_level", 32'(lvl1), 32'd1);
    @(posedge clk); #1;
    rr1 = 1'b1;
    @(negedge clk);
    chk("lat_c2_validR", 32'(vr1), 32'd1);
    chk("lat_c2_dataR", 32'(dr1), 32'hA5);
    @(posedge clk); #1;
    rr1 = 1'b0;
    @(negedge clk);
    chk("lat_drained_validR", 32'(vr1), 32'd0);
    chk("lat_drained_level", 32'(lvl1), 32'd0);
    @(posedge clk); #1;

    // Fill to capacity of five, sixth write refused
    for (int i = 0; i < 6; i++) begin
      vw1 = 1'b1; dw1 = 8'(i + 1); rr1 = 1'b0;
      @(negedge clk);
      chk($sformatf("fill%0d_readyW", i), 32'(rdyw1), 32'(i < 5));
      chk($sformatf("fill%0d_level", i), 32'(lvl1), 32'(i));
      @(posedge clk); #1;
    end
    vw1 = 1'b0;
    @(negedge clk);
    chk("full_level", 32'(lvl1), 32'd5);
    chk("full_afull", 32'(af1), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      rr1 = 1'b1;
      @(negedge clk);
      chk($sformatf("drain%0d_validR", i), 32'(vr1), 32'd1);
      chk($sformatf("drain%0d_dataR", i), 32'(dr1), 32'(i + 1));
      @(posedge clk); #1;
    end
    rr1 = 1'b0;
    @(negedge clk);
    chk("drain_end_validR", 32'(vr1), 32'd0);
    chk("drain_end_level", 32'(lvl1), 32'd0);
    chk("drain_end_aempty", 32'(ae1), 32'd1);
    @(posedge clk); #1;

    // Random back-pressure against a reference queue
    sent = 0; got = 0; hold = 1'b0; hdata = '0;
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      vw1 = (sent < 200) && ($urandom_range(3) != 0);
      dw1 = 8'(sent);
      rr1 = ($urandom_range(1) == 1);
      @(negedge clk);
      chk("bp_level", 32'(lvl1), 32'(q.size()));
      chk("bp_afull", 32'(af1), 32'(q.size() >= 3));
      chk("bp_aempty", 32'(ae1), 32'(q.size() <= 1));
      if (hold) begin
        chk("bp_hold_validR", 32'(vr1), 32'd1);
        chk("bp_hold_dataR", 32'(dr1), 32'(hdata));
      end
      if (vr1 && rr1) begin
        if (q.size() == 0) begin
          chk("bp_spurious_read", 32'd1, 32'd0);
        end else begin
          chk("bp_dataR", 32'(dr1), 32'(q.pop_front()));
        end
        got++;
      end
      if (vw1 && rdyw1) begin
        q.push_back(dw1);
        sent++;
      end
      hold  = vr1 && !rr1;
      hdata = dr1;
      @(posedge clk); #1;
    end
    chk("bp_words_received", 32'(got), 32'd200);
    vw1 = 1'b0; rr1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
